drive_cmd_encoder: RTL

Consumes the keyboard decoder's key-state outputs (`key_down`, `last_change`, `key_valid`) on the master FPGA. It maps the held driving keys to a single 8-bit drive command byte and streams that byte to the Bluetooth UART transmitter over a valid/ready handshake. A byte is sent when the command changes, and re-sent periodically as a keepalive so the car's slave FPGA can detect link loss.

---
 rtl/drive_cmd_pkg.sv | 27 ++
 rtl/drive_cmd_map.sv | 27 ++
 rtl/drive_cmd_encoder.sv | 96 +++++++++
 3 files changed

// File: rtl/drive_cmd_pkg.sv
// drive_cmd_pkg: scancodes, command byte layout and FSM states for the drive command encoder
package drive_cmd_pkg;
    localparam logic [8:0] SC_W     = 9'h01D;
    localparam logic [8:0] SC_UP    = 9'h175;
    localparam logic [8:0] SC_S     = 9'h01B;
    localparam logic [8:0] SC_DOWN  = 9'h172;
    localparam logic [8:0] SC_A     = 9'h01C;
    localparam logic [8:0] SC_LEFT  = 9'h16B;
    localparam logic [8:0] SC_D     = 9'h023;
    localparam logic [8:0] SC_RIGHT = 9'h174;
    localparam logic [8:0] SC_SPACE = 9'h029;

    localparam logic [2:0] CMD_HDR     = 3'b101;
    localparam logic [7:0] CMD_NEUTRAL = 8'hA0;

    localparam int BIT_BRAKE = 4;
    localparam int BIT_FWD   = 3;
    localparam int BIT_REV   = 2;
    localparam int BIT_LEFT  = 1;
    localparam int BIT_RIGHT = 0;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

    function automatic logic is_mapped(input logic [8:0] code);
        return code inside {SC_W, SC_UP, SC_S, SC_DOWN, SC_A, SC_LEFT, SC_D, SC_RIGHT, SC_SPACE};
    endfunction
endpackage

// File: rtl/drive_cmd_map.sv
// drive_cmd_map: held-key bitmap to drive command byte with conflict resolution
module drive_cmd_map
    import drive_cmd_pkg::*;
(
    input  logic [511:0] key_down,
    output logic [7:0]   new_cmd
);
    logic fwd, rev, left, right, brake;
    logic unused_keys;

    assign unused_keys = ^key_down;

    // opposing keys cancel, brake overrides all steering and throttle
    always_comb begin
        fwd   = key_down[SC_W] | key_down[SC_UP];
        rev   = key_down[SC_S] | key_down[SC_DOWN];
        left  = key_down[SC_A] | key_down[SC_LEFT];
        right = key_down[SC_D] | key_down[SC_RIGHT];
        brake = key_down[SC_SPACE];
        new_cmd = {CMD_HDR, 5'b0};
        new_cmd[BIT_BRAKE] = brake;
        new_cmd[BIT_FWD]   = fwd & ~rev & ~brake;
        new_cmd[BIT_REV]   = rev & ~fwd & ~brake;
        new_cmd[BIT_LEFT]  = left & ~right & ~brake;
        new_cmd[BIT_RIGHT] = right & ~left & ~brake;
    end
endmodule

// File: rtl/drive_cmd_encoder.sv
// drive_cmd_encoder: streams the drive command byte on change and as a periodic keepalive
module drive_cmd_encoder
    import drive_cmd_pkg::*;
#(
    parameter int KEEPALIVE_CYCLES = 10_000_000,
    parameter int GAP_CYCLES       = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         key_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [7:0]   cmd_now
);
    localparam int KW = $clog2(KEEPALIVE_CYCLES);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [KW-1:0] KA_LAST = KW'(KEEPALIVE_CYCLES - 1);
    localparam logic [KW-1:0] KA_EXP  = KW'(KEEPALIVE_CYCLES - 2);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d, data_q, data_d, new_cmd;
    logic          valid_q, valid_d, pend_q, pend_d;
    logic [KW-1:0] ka_q, ka_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          change, accept, expire, launch;

    drive_cmd_map u_map (
        .key_down (key_down),
        .new_cmd  (new_cmd)
    );

    // command tracking and keepalive; an expiry coinciding with a change defers to the change so only the new byte goes out
    always_comb begin
        change = key_valid && is_mapped(last_change) && new_cmd != cmd_q;
        accept = valid_q && tx_ready;
        expire = !accept && ka_q == KA_EXP;
        launch = state_q == IDLE && (pend_q || (expire && !change));
        cmd_d  = change ? new_cmd : cmd_q;
        pend_d = change || (expire && !launch) || (pend_q && !launch);
        ka_d   = accept ? '0 : (ka_q == KA_LAST ? ka_q : ka_q + 1'b1);
    end

    // handshake FSM: offer a byte, hold it until accepted, then enforce the idle gap
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: if (launch) begin
                state_d = SEND;
                data_d  = cmd_q;
                valid_d = 1'b1;
            end
            SEND: if (tx_ready) begin
                state_d = GAP;
                valid_d = 1'b0;
                gap_d   = GAP_LOAD;
            end
            GAP: begin
                state_d = gap_q == '0 ? IDLE : GAP;
                gap_d   = gap_q == '0 ? gap_q : gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= CMD_NEUTRAL;
            data_q  <= CMD_NEUTRAL;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            ka_q    <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            ka_q    <= ka_d;
            gap_q   <= gap_d;
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = valid_q;
    assign cmd_now  = cmd_q;
endmodule
